// File: rtl/serial_transmitter_if.sv
// Producer-side handshake and line outputs of the single-wire serial transmitter.
interface serial_transmitter_if #(
    parameter int DATA_BITS = 7
);
    logic [DATA_BITS-1:0] data_in;
    logic                 valid;
    logic                 ready;
    logic                 serial_out;
    logic                 busy;
    logic                 done;

    modport master (
        output data_in, valid,
        input  ready, serial_out, busy, done
    );

    modport slave (
        input  data_in, valid,
        output ready, serial_out, busy, done
    );
endinterface

// File: rtl/serial_transmitter.sv
// Frame serialiser: start(0), data LSB-first, parity, stop(1)s; one-word holding buffer
// allows back-to-back frames with no idle bit between them.
module serial_transmitter #(
    parameter int DATA_BITS    = 7,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_ODD   = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    serial_transmitter_if.slave  tx
);
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_nxt;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_nxt;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [DATA_BITS-1:0] buf_q, buf_nxt;
    logic                 par_q, par_nxt;
    logic                 buf_full_q, buf_full_nxt;
    logic                 line_q, line_nxt;
    logic                 busy_q;
    logic                 done_q, done_nxt;
    logic                 accept, bit_end, frame_end;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY_ODD != 0) ? ~^d : ^d;
    endfunction

    assign tx.ready      = !buf_full_q;
    assign tx.serial_out = line_q;
    assign tx.busy       = busy_q;
    assign tx.done       = done_q;

    assign accept    = tx.valid && !buf_full_q;
    assign bit_end   = (clk_cnt_q == CLK_LAST);
    assign frame_end = (state_q == STOP) && bit_end && (bit_cnt_q == STOP_LAST);

    always_comb begin
        state_nxt    = state_q;
        clk_cnt_nxt  = (state_q == IDLE || bit_end) ? '0 : clk_cnt_q + 1'b1;
        bit_cnt_nxt  = bit_cnt_q;
        shift_nxt    = shift_q;
        par_nxt      = par_q;
        buf_nxt      = buf_q;
        buf_full_nxt = buf_full_q;
        done_nxt     = 1'b0;
        line_nxt     = 1'b1;

        case (state_q)
            IDLE: begin
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        state_nxt   = PARITY;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_nxt   = IDLE;
                        bit_cnt_nxt = '0;
                        done_nxt    = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A queued word wins at frame end; a word offered on the final stop edge chains directly.
        if (frame_end && buf_full_q) begin
            shift_nxt    = buf_q;
            par_nxt      = parity_of(buf_q);
            buf_full_nxt = 1'b0;
            state_nxt    = START;
        end else if (accept && (state_q == IDLE || frame_end)) begin
            shift_nxt = tx.data_in;
            par_nxt   = parity_of(tx.data_in);
            state_nxt = START;
        end else if (accept) begin
            buf_nxt      = tx.data_in;
            buf_full_nxt = 1'b1;
        end

        case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = shift_nxt[0];
            PARITY:  line_nxt = par_nxt;
            default: line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            buf_full_q <= 1'b0;
            line_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            clk_cnt_q  <= clk_cnt_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            buf_full_q <= buf_full_nxt;
            line_q     <= line_nxt;
            busy_q     <= (state_nxt != IDLE);
            done_q     <= done_nxt;
        end
    end

    // Word storage only; validity is tracked by the reset control state above.
    always_ff @(posedge clk) begin
        shift_q <= shift_nxt;
        buf_q   <= buf_nxt;
        par_q   <= par_nxt;
    end
endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter: default, even-parity and slow/two-stop instances.
module tb_serial_transmitter;
    logic clk;
    logic rstn;
    int   errors;
    int   checks;
    logic [39:0] cap;

    serial_transmitter_if #(.DATA_BITS(7)) if_a ();
    serial_transmitter_if #(.DATA_BITS(7)) if_b ();
    serial_transmitter_if #(.DATA_BITS(7)) if_c ();

    serial_transmitter #(.DATA_BITS(7), .STOP_BITS(1), .CLKS_PER_BIT(1), .PARITY_ODD(1))
        dut_a (.clk(clk), .rstn(rstn), .tx(if_a));
    serial_transmitter #(.DATA_BITS(7), .STOP_BITS(1), .CLKS_PER_BIT(1), .PARITY_ODD(0))
        dut_b (.clk(clk), .rstn(rstn), .tx(if_b));
    serial_transmitter #(.DATA_BITS(7), .STOP_BITS(2), .CLKS_PER_BIT(4), .PARITY_ODD(1))
        dut_c (.clk(clk), .rstn(rstn), .tx(if_c));

    typedef struct {
        int          sel;
        logic [6:0]  data;
        logic [15:0] exp;
        int          nbits;
        int          cpb;
    } vec_t;

    vec_t vecs [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {serial_out, ready, busy, done}
    function automatic logic [3:0] obs(input int sel);
        case (sel)
            0:       return {if_a.serial_out, if_a.ready, if_a.busy, if_a.done};
            1:       return {if_b.serial_out, if_b.ready, if_b.busy, if_b.done};
            default: return {if_c.serial_out, if_c.ready, if_c.busy, if_c.done};
        endcase
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [6:0] d);
        case (sel)
            0:       begin if_a.valid = v; if_a.data_in = d; end
            1:       begin if_b.valid = v; if_b.data_in = d; end
            default: begin if_c.valid = v; if_c.data_in = d; end
        endcase
    endtask

    task automatic run_frame(input int idx);
        vec_t        v;
        logic [3:0]  o;
        logic [15:0] e;
        int          len;
        v   = vecs[idx];
        e   = v.exp;
        len = v.nbits * v.cpb;
        set_in(v.sel, 1'b1, v.data);
        tick();
        set_in(v.sel, 1'b0, ~v.data);
        o = obs(v.sel);
        chk($sformatf("v%0d ready after direct load", idx), 32'(o[2]), 32'd1);
        for (int k = 1; k <= len; k++) begin
            o = obs(v.sel);
            chk($sformatf("v%0d line c%0d", idx, k), 32'(o[3]), 32'(e[(k-1)/v.cpb]));
            chk($sformatf("v%0d busy c%0d", idx, k), 32'(o[1]), 32'd1);
            chk($sformatf("v%0d done early c%0d", idx, k), 32'(o[0]), 32'd0);
            tick();
        end
        o = obs(v.sel);
        chk($sformatf("v%0d done pulse", idx), 32'(o[0]), 32'd1);
        chk($sformatf("v%0d busy after", idx), 32'(o[1]), 32'd0);
        chk($sformatf("v%0d idle line", idx), 32'(o[3]), 32'd1);
        tick();
        o = obs(v.sel);
        chk($sformatf("v%0d done single", idx), 32'(o[0]), 32'd0);
    endtask

    // Loopback receiver view of one captured 10-bit frame.
    task automatic decode_chk(input int f, input logic [6:0] exp_d);
        int         b;
        logic [6:0] d;
        b = f * 10;
        d = cap[b+1 +: 7];
        chk($sformatf("f%0d start", f), 32'(cap[b]), 32'd0);
        chk($sformatf("f%0d data_out", f), 32'(d), 32'(exp_d));
        chk($sformatf("f%0d parity_ok_n", f), 32'(~^{d, cap[b+8]}), 32'd0);
        chk($sformatf("f%0d stop", f), 32'(cap[b+9]), 32'd1);
    endtask

    initial begin
        logic [3:0] o;
        int         acc_cycle;
        int         bad;
        logic       drop;

        errors = 0;
        checks = 0;
        cap    = '0;
        vecs[0] = '{0, 7'h41, 16'b1110000010,  10, 1};
        vecs[1] = '{0, 7'h00, 16'b1100000000,  10, 1};
        vecs[2] = '{0, 7'h7F, 16'b1011111110,  10, 1};
        vecs[3] = '{0, 7'h55, 16'b1110101010,  10, 1};
        vecs[4] = '{0, 7'h2A, 16'b1001010100,  10, 1};
        vecs[5] = '{1, 7'h00, 16'b1000000000,  10, 1};
        vecs[6] = '{1, 7'h7F, 16'b1111111110,  10, 1};
        vecs[7] = '{1, 7'h41, 16'b1010000010,  10, 1};
        vecs[8] = '{2, 7'h41, 16'b11110000010, 11, 4};

        rstn = 1'b0;
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 7'h00);
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset state dut%0d", s), 32'(obs(s)), 32'b1100);
        end
        rstn = 1'b1;
        tick();
        tick();
        chk("post-reset idle", 32'(obs(0)), 32'b1100);

        for (int i = 0; i < 9; i++) run_frame(i);

        // Back-to-back 55 then 2A with valid held.
        set_in(0, 1'b1, 7'h55);
        tick();
        for (int i = 0; i < 20; i++) begin
            o = obs(0);
            cap[i] = o[3];
            chk($sformatf("b2b ready c%0d", i+1), 32'(o[2]), (i >= 1 && i <= 9) ? 32'd0 : 32'd1);
            chk($sformatf("b2b busy c%0d", i+1), 32'(o[1]), 32'd1);
            chk($sformatf("b2b done c%0d", i+1), 32'(o[0]), (i == 10) ? 32'd1 : 32'd0);
            if (i == 0) set_in(0, 1'b1, 7'h2A);
            if (i == 1) set_in(0, 1'b0, 7'h00);
            tick();
        end
        o = obs(0);
        chk("b2b final done", 32'(o[0]), 32'd1);
        chk("b2b final busy", 32'(o[1]), 32'd0);
        chk("b2b frames", 32'(cap[19:0]), 32'b10010101001110101010);
        decode_chk(0, 7'h55);
        decode_chk(1, 7'h2A);
        tick();

        // Backpressure: third word offered while the buffer is full.
        acc_cycle = 0;
        set_in(0, 1'b1, 7'h13);
        tick();
        for (int i = 0; i < 30; i++) begin
            o = obs(0);
            cap[i] = o[3];
            chk($sformatf("bp busy c%0d", i+1), 32'(o[1]), 32'd1);
            if (i == 0) set_in(0, 1'b1, 7'h64);
            if (i == 1) set_in(0, 1'b1, 7'h3C);
            drop = (i >= 1) && if_a.valid && o[2];
            if (drop) acc_cycle = i + 1;
            tick();
            if (drop) set_in(0, 1'b0, 7'h00);
        end
        chk("bp third accept cycle", 32'(acc_cycle), 32'd11);
        chk("bp frames", 32'(cap[29:0]), 32'b110111100010110010001000100110);
        decode_chk(0, 7'h13);
        decode_chk(1, 7'h64);
        decode_chk(2, 7'h3C);
        o = obs(0);
        chk("bp done end", 32'(o[0]), 32'd1);
        chk("bp busy end", 32'(o[1]), 32'd0);
        tick();
        chk("bp idle after", 32'(obs(0)), 32'b1100);

        // Reset mid-frame with a word queued.
        set_in(0, 1'b1, 7'h00);
        tick();
        set_in(0, 1'b1, 7'h7F);
        tick();
        chk("rst-mid buffered", 32'(obs(0) & 4'b0100), 32'd0);
        set_in(0, 1'b0, 7'h00);
        tick();
        chk("rst-mid line low", 32'(obs(0)), 32'b0010);
        #2 rstn = 1'b0;
        #1;
        chk("rst-mid async outputs", 32'(obs(0)), 32'b1100);
        tick();
        tick();
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (obs(0) != 4'b1100) bad++;
        end
        chk("rst-mid no restart", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
